// File: rtl/hex_display_scanner.sv
// Four-digit common-anode seven-segment scanner. The shown 16-bit half is snapshotted once per
// frame so a digit sequence never mixes two values; optional leading-zero blanking.
module hex_display_scanner #(
  parameter int unsigned REFRESH_DIV = 100_000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_value,
  input  logic        i_lower_bytes,
  input  logic        i_blank_lz,
  output logic [6:0]  o_seg,
  output logic [3:0]  o_an
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [31:0]      r_snap_val;
  logic             r_snap_lo;
  logic             r_load_pending;
  logic [6:0]       r_seg;
  logic [3:0]       r_an;

  logic             w_wrap;
  logic             w_load;
  logic [15:0]      w_half;
  logic [3:0]       w_nib;
  logic             w_blank;
  logic [6:0]       w_dec;

  assign w_wrap = (r_cnt == CNT_LAST);
  assign w_load = r_load_pending || (w_wrap && (r_idx == 2'd3));
  assign w_half = r_snap_lo ? r_snap_val[15:0] : r_snap_val[31:16];
  assign w_nib  = w_half[{r_idx, 2'b00} +: 4];

  // A digit is blank only if it and every more-significant digit are zero; digit 0 always shows.
  always_comb begin
    w_blank = 1'b0;
    unique case (r_idx)
      2'd0: w_blank = 1'b0;
      2'd1: w_blank = i_blank_lz && (w_half[15:4] == 12'h000);
      2'd2: w_blank = i_blank_lz && (w_half[15:8] == 8'h00);
      2'd3: w_blank = i_blank_lz && (w_half[15:12] == 4'h0);
      default: w_blank = 1'b0;
    endcase
  end

  // seg[6:0] = gfedcba, active low
  always_comb begin
    w_dec = SEG_OFF;
    unique case (w_nib)
      4'h0: w_dec = 7'b1000000;
      4'h1: w_dec = 7'b1111001;
      4'h2: w_dec = 7'b0100100;
      4'h3: w_dec = 7'b0110000;
      4'h4: w_dec = 7'b0011001;
      4'h5: w_dec = 7'b0010010;
      4'h6: w_dec = 7'b0000010;
      4'h7: w_dec = 7'b1111000;
      4'h8: w_dec = 7'b0000000;
      4'h9: w_dec = 7'b0010000;
      4'hA: w_dec = 7'b0001000;
      4'hB: w_dec = 7'b0000011;
      4'hC: w_dec = 7'b1000110;
      4'hD: w_dec = 7'b0100001;
      4'hE: w_dec = 7'b0000110;
      4'hF: w_dec = 7'b0001110;
      default: w_dec = SEG_OFF;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt          <= '0;
      r_idx          <= 2'd0;
      r_snap_val     <= 32'h0;
      r_snap_lo      <= 1'b1;
      r_load_pending <= 1'b1;
      r_an           <= 4'b1111;
      r_seg          <= SEG_OFF;
    end else begin
      if (w_wrap) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_load) begin
        r_snap_val <= i_value;
        r_snap_lo  <= i_lower_bytes;
      end
      r_load_pending <= 1'b0;
      r_an           <= ~(4'b0001 << r_idx);
      r_seg          <= w_blank ? SEG_OFF : w_dec;
    end
  end

  assign o_seg = r_seg;
  assign o_an  = r_an;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: directed frame table, reset corner cases, and random stimulus
// checked each cycle against a frame-position model.
module tb_hex_display_scanner;

  localparam int unsigned D = 4;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_value;
  logic        i_lower_bytes;
  logic        i_blank_lz;
  logic [6:0]  o_seg;
  logic [3:0]  o_an;

  int n_pass = 0;
  int n_total = 0;

  hex_display_scanner #(.REFRESH_DIV(D)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_value      (i_value),
    .i_lower_bytes(i_lower_bytes),
    .i_blank_lz   (i_blank_lz),
    .o_seg        (o_seg),
    .o_an         (o_an)
  );

  always #5 clk = ~clk;

  // Model: position k counts edges since reset release; digit shown = (k / D) mod 4,
  // snapshot refreshed on the first edge and on the last edge of every 4*D frame.
  logic [6:0]  lut [16];
  int          m_k = 0;
  logic [31:0] m_snap = 32'h0;
  logic        m_lo = 1'b1;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;

  initial begin
    lut[0]  = 7'b1000000; lut[1]  = 7'b1111001; lut[2]  = 7'b0100100; lut[3]  = 7'b0110000;
    lut[4]  = 7'b0011001; lut[5]  = 7'b0010010; lut[6]  = 7'b0000010; lut[7]  = 7'b1111000;
    lut[8]  = 7'b0000000; lut[9]  = 7'b0010000; lut[10] = 7'b0001000; lut[11] = 7'b0000011;
    lut[12] = 7'b1000110; lut[13] = 7'b0100001; lut[14] = 7'b0000110; lut[15] = 7'b0001110;
  end

  always @(posedge clk) begin
    int   d;
    int   h;
    int   upper;
    if (i_reset) begin
      m_an   = 4'b1111;
      m_seg  = 7'b1111111;
      m_k    = 0;
      m_snap = 32'h0;
      m_lo   = 1'b1;
    end else begin
      d     = (m_k / D) % 4;
      h     = m_lo ? int'(m_snap[15:0]) : int'(m_snap[31:16]);
      upper = h / (1 << (4 * d));
      m_an  = 4'b1111 ^ (4'b0001 << d);
      if (i_blank_lz && d != 0 && upper == 0) m_seg = 7'b1111111;
      else m_seg = lut[upper % 16];
      if (m_k == 0 || (m_k % (4 * D)) == (4 * D - 1)) begin
        m_snap = i_value;
        m_lo   = i_lower_bytes;
      end
      m_k = m_k + 1;
    end
  end

  task automatic chk(input string nm, input logic [3:0] an_exp, input logic [6:0] seg_exp);
    n_total++;
    if (o_an !== an_exp || o_seg !== seg_exp)
      $display("FAIL %s @%0t: an=%b seg=%b, required an=%b seg=%b",
               nm, $time, o_an, o_seg, an_exp, seg_exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("model", m_an, m_seg);
  endtask

  typedef struct {
    logic [31:0]     value;
    logic            lower;
    logic            blank;
    logic [3:0][6:0] seg;
  } frame_t;

  localparam int NF = 8;
  frame_t tab [NF];

  initial begin
    logic [3:0] exp_an;
    tab[0] = '{32'h1234_ABCD, 1'b1, 1'b0, {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}};
    tab[1] = '{32'h1234_ABCD, 1'b0, 1'b0, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
    tab[2] = '{32'h0000_0005, 1'b1, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010}};
    tab[3] = '{32'h0000_0000, 1'b1, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};
    tab[4] = '{32'h0000_0500, 1'b1, 1'b1, {7'b1111111, 7'b0010010, 7'b1000000, 7'b1000000}};
    tab[5] = '{32'h0000_1111, 1'b1, 1'b0, {7'b1111001, 7'b1111001, 7'b1111001, 7'b1111001}};
    tab[6] = '{32'h0000_2222, 1'b1, 1'b0, {7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100}};
    tab[7] = '{32'h00A0_FFFF, 1'b0, 1'b1, {7'b1111111, 7'b1111111, 7'b0001000, 7'b1000000}};

    // Reset and first-edge behaviour
    i_reset = 1'b1; i_value = 32'h0000_0001; i_lower_bytes = 1'b1; i_blank_lz = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset", 4'b1111, 7'b1111111);
    end
    i_reset = 1'b0;
    step();
    chk("first_edge_old_snap", 4'b1110, 7'b1000000);
    step();
    chk("first_edge_new_snap", 4'b1110, 7'b1111001);

    // Frame table: next frame's value is changed mid-frame (idx=1) to exercise the freeze
    i_reset = 1'b1;
    i_value = tab[0].value; i_lower_bytes = tab[0].lower; i_blank_lz = tab[0].blank;
    step();
    step();
    i_reset = 1'b0;
    step();
    for (int f = 0; f < NF; f++) begin
      for (int j = (f == 0) ? 1 : 0; j < 4 * D; j++) begin
        step();
        exp_an = 4'b1111 ^ (4'b0001 << (j / D));
        chk($sformatf("frame%0d_step%0d", f, j), exp_an, tab[f].seg[j / D]);
        if (j == 5 && f + 1 < NF) begin
          i_value = tab[f + 1].value;
          i_lower_bytes = tab[f + 1].lower;
        end
        if (j == 4 * D - 1 && f + 1 < NF) i_blank_lz = tab[f + 1].blank;
      end
    end

    // Mid-frame reset at idx=2, cnt=1
    for (int j = 0; j < 9; j++) step();
    i_reset = 1'b1; i_value = 32'h0000_00C3; i_lower_bytes = 1'b1; i_blank_lz = 1'b0;
    step();
    chk("midframe_reset", 4'b1111, 7'b1111111);
    i_reset = 1'b0;
    step();
    chk("midframe_release", 4'b1110, 7'b1000000);
    for (int j = 1; j < D; j++) begin
      step();
      chk("midframe_digit0", 4'b1110, 7'b0110000);
    end
    step();
    chk("midframe_digit1", 4'b1101, 7'b1000110);

    // Random stimulus against the model
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 63) == 0) i_reset = 1'b1;
      else i_reset = 1'b0;
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: i_value = $urandom;
          1: i_value = $urandom & 32'h000F_000F;
          2: i_value = 32'h0;
          default: i_value = $urandom & 32'h00FF_0F00;
        endcase
      end
      if ($urandom_range(0, 15) == 0) i_lower_bytes = ~i_lower_bytes;
      if ($urandom_range(0, 9) == 0) i_blank_lz = ~i_blank_lz;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hex_display_scanner.md
# hex_display_scanner

Time-multiplexed driver for the board's four-digit, common-anode seven-segment display. It sits directly downstream of the debug-value selector in the board top level and consumes that selector's 32-bit output. It shows one 16-bit half of the value as four hex digits. The value is snapshotted once per scan frame so the display never tears. Optional leading-zero blanking is provided.

## Interface
- REFRESH_DIV, default 100_000: clk cycles each digit is lit; legal range ≥ 2. The default gives 1 ms per digit and a 250 Hz frame at 100 MHz.
- clk  in  1  main board clock (fast clock, not the CPU slow clock).
- reset  in  1  synchronous, active-high reset.
- value  in  32  word to display (PC, instruction, ALU result, etc.).
- lower_bytes  in  1  1 = show value[15:0]; 0 = show value[31:16].
- blank_lz  in  1  1 = blank leading zero digits (digit 0 never blanked).
- seg  out  7  segment cathodes, active low; seg[0]=a … seg[6]=g.
- an  out  4  digit anodes, active low; an[0] = rightmost digit.

## Operation
- State:
  - tick counter cnt, width $clog2(REFRESH_DIV).
  - digit index idx[1:0].
  - snapshot registers snap_val[31:0] and snap_lo.
  - load_pending flag.
  - registered seg and an outputs.
- Reset values: cnt=0, idx=0, snap_val=0, snap_lo=1, load_pending=1, an=4'b1111, seg=7'b1111111.
- Tick counter:
  - cnt increments every non-reset cycle.
  - When cnt==REFRESH_DIV-1, cnt wraps to 0 and idx advances 0→1→2→3→0.
- Snapshot load: snap_val<=value and snap_lo<=lower_bytes when either condition holds:
  - load_pending==1 (first non-reset cycle; load_pending then clears), or
  - cnt==REFRESH_DIV-1 with idx==3 (frame wrap).
- Snapshot freeze: value and lower_bytes are ignored at all other times.
- Displayed half: h = snap_lo ? snap_val[15:0] : snap_val[31:16]; digit i shows nibble h[4i+3:4i].
- Leading-zero blanking: digit i (i=1..3) is blanked when blank_lz==1 and h[15:4i]==0.
  - Blank means seg=7'b1111111; the anode is still driven.
  - blank_lz is sampled live, not snapshotted.
- Output registers, updated every non-reset cycle from the current idx and snapshot:
  - an <= ~(4'b0001 << idx).
  - seg <= blank ? 7'b1111111 : decode(nibble).
- Decode (seg[6:0] = gfedcba, active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Only one anode is ever low outside reset; no state in which two digits are lit.

## Timing
- Outputs are registered: an idx change at edge N appears on an/seg at edge N+1.
- Digit dwell is exactly REFRESH_DIV cycles; a frame is 4·REFRESH_DIV cycles.
- First edge with reset low (edge R):
  - snapshot loads.
  - Outputs show digit 0 of the old snapshot (0): an=1110, seg=1000000.
  - From edge R+1, outputs show the new snapshot.
- value/lower_bytes latency: a change becomes visible at the first frame wrap after it. Worst case is 4·REFRESH_DIV+1 cycles.
- Reset asserted mid-frame: at the next edge all state and outputs return to reset values, regardless of cnt/idx.
- If value changes in the same cycle as the frame-wrap load, the new value is captured.

## Test plan
Run with REFRESH_DIV=4.
- Reset: hold reset 3 cycles → an=1111, seg=1111111. Release with value=0x0000_0001 → at R: an=1110, seg=1000000; at R+1: seg=1111001.
- Scan, lower half: value=0x1234_ABCD, lower_bytes=1, blank_lz=0 → over one 16-cycle frame:
  - an cycles 1110,1101,1011,0111, each held 4 cycles.
  - seg = d(0100001), C(1000110), b(0000011), A(0001000).
  - Set lower_bytes=0 → next frame shows 4,3,2,1.
- Blanking: value=0x0000_0005, lower_bytes=1, blank_lz=1 → digit 0 shows 0010010; digits 1–3 show seg=1111111 with their an low.
  - value=0 → digit 0 shows 1000000, others blank.
  - value=0x0000_0500 → digit 1 shows 1000000 (not blanked).
- Tear-free snapshot: change value from 0x0000_1111 to 0x0000_2222 while idx=1 → digits 2 and 3 of that frame still show 1111001.
  - The next frame shows 0100100 on all four digits.
- Mid-frame reset: assert reset for 1 cycle at idx=2, cnt=1 → next edge an=1111, seg=1111111, idx=0, cnt=0.
  - The snapshot reloads on the first cycle after release.
